alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 clrn  in  1  synchronous active-low reset, sampled on rising clk.
REQ-004 in_valid  in  1  decode slot holds a real instruction.
REQ-005 rs, rt  in  5 each  source register numbers.
REQ-006 imm  in  16  instruction immediate; imm[10:6] is the shift amount.
REQ-007 d_aluc  in  4  ALU op, encoded as the ALU expects: x000 ADD, x001 AND, x010 XOR, x100 SUB, x101 OR, x110 LUI, 0011 SLL, 0111 SRL, 1111 SRA.
REQ-008 d_aluimm  in  1  b operand = extended imm instead of rt value.
REQ-009 d_sext  in  1  sign-extend imm (1) or zero-extend (0).
REQ-010 d_shift  in  1  a operand = zero-extended imm[10:6] instead of rs value.
REQ-011 d_wreg, d_rn  in  1, 5  instruction writes a register, and which one.
REQ-012 stall  in  1  hold the execute register.
REQ-013 flush  in  1  load a bubble into the execute register.
REQ-014 wb_we, wb_rn, wb_d  in  1, 5, 32  write-back port.
REQ-015 a, b  out  32 each  registered ALU operands.
REQ-016 aluc  out  4  registered ALU op.
REQ-017 e_valid, e_wreg, e_rn  out  1, 1, 5  registered execute-stage tags.

Function
REQ-018 Register file: 32 x 32 bits. Register 0 SHALL read as 0. Writes to register 0 SHALL be ignored.
REQ-019 Write: on rising clk when clrn=1, wb_we=1 and wb_rn!=0, reg[wb_rn] <= wb_d.
REQ-020 Read: rs and rt are read combinationally. When wb_we=1 and wb_rn equals the nonzero source number, the read SHALL return wb_d (same-cycle write-through).
REQ-021 Extension: ext = d_sext ? {16{imm[15]},imm} : {16'h0,imm}.
REQ-022 Next a = d_shift ? {27'h0,imm[10:6]} : read(rs).
REQ-023 Next b = d_aluimm ? ext : read(rt).
REQ-024 Latency: decode inputs SHALL appear on a/b/aluc/e_* exactly one clk after capture.
REQ-025 Update priority per rising clk: reset > flush > stall > load.
REQ-026 Flush, or load with in_valid=0, SHALL produce a bubble: a=b=0, aluc=0000, e_valid=0, e_wreg=0, e_rn=0.
REQ-027 Stall with no flush SHALL hold all execute outputs unchanged. Register-file writes SHALL still occur during stall.
REQ-028 Load with in_valid=1 SHALL capture the REQ-022/023 operands plus d_aluc, d_wreg and d_rn, and set e_valid=1.
REQ-029 During load, e_wreg SHALL be forced to 0 when d_rn=0.
REQ-030 Held operands are not re-read during stall. The hazard controller owns operand freshness across stalls.
REQ-031 stall and flush asserted together: flush wins.

Reset
REQ-032 With clrn=0 at a rising clk, registers 1..31 SHALL clear to 0 and the execute register SHALL take the bubble value of REQ-026. This applies regardless of stall, flush or wb_we.
REQ-033 Reset SHALL take effect mid-stall or mid-write. A write-back presented in the reset cycle SHALL be discarded.
REQ-034 No output SHALL change asynchronously on clrn.

Verification
REQ-035 Reset: hold clrn=0 for 2 clk, then read rs=5, rt=31 -> a=0, b=0, e_valid=0 one clk after release.
REQ-036 Write-through: wb_we=1, wb_rn=3, wb_d=32'hDEADBEEF, in the same cycle rs=3, in_valid=1 -> next clk a=32'hDEADBEEF. Write to rn=0 with 32'hFFFFFFFF, then rs=0 -> a=0.
REQ-037 Immediate: imm=16'h8001, d_aluimm=1, d_sext=1 -> b=32'hFFFF8001. With d_sext=0 -> b=32'h00008001. d_shift=1, imm[10:6]=5'd17 -> a=32'd17.
REQ-038 Stall/flush: load an instruction with aluc=0100, then stall 3 clk while changing inputs -> outputs constant. Assert stall and flush together -> bubble next clk.
REQ-039 Tag rules: in_valid=1, d_wreg=1, d_rn=0 -> e_valid=1, e_wreg=0. in_valid=0 -> full bubble.
REQ-040 Mid-operation reset: stall asserted with wb_we=1 to register 7, clrn=0 in that cycle -> reg 7 reads 0 afterwards and outputs are a bubble.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ALU issue stage: 32x32 register file with write-through reads, operand
// selection (register / extended immediate / shift amount) and the
// execute pipeline register with stall, flush and bubble handling.
module alu_issue_stage (
  input  logic        clk,
  input  logic        clrn,
  input  logic        in_valid,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [15:0] imm,
  input  logic [3:0]  d_aluc,
  input  logic        d_aluimm,
  input  logic        d_sext,
  input  logic        d_shift,
  input  logic        d_wreg,
  input  logic [4:0]  d_rn,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_rn,
  input  logic [31:0] wb_d,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  aluc,
  output logic        e_valid,
  output logic        e_wreg,
  output logic [4:0]  e_rn
);

  logic [31:0] rf_q [32];

  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  aluc_q, aluc_d;
  logic        e_valid_q, e_valid_d;
  logic        e_wreg_q, e_wreg_d;
  logic [4:0]  e_rn_q, e_rn_d;

  logic [31:0] rs_val, rt_val, ext;

  // Register-file reads: r0 is hard zero, a same-cycle write-back bypasses the array
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != 5'd0) begin
      if (wb_we && (wb_rn == rs)) rs_val = wb_d;
      else                        rs_val = rf_q[rs];
    end
    if (rt != 5'd0) begin
      if (wb_we && (wb_rn == rt)) rt_val = wb_d;
      else                        rt_val = rf_q[rt];
    end
  end

  // Operand selection and execute-register next state (reset > flush > stall > load)
  always_comb begin
    ext       = d_sext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    a_d       = a_q;
    b_d       = b_q;
    aluc_d    = aluc_q;
    e_valid_d = e_valid_q;
    e_wreg_d  = e_wreg_q;
    e_rn_d    = e_rn_q;
    if (!clrn || flush || (!stall && !in_valid)) begin
      a_d       = '0;
      b_d       = '0;
      aluc_d    = '0;
      e_valid_d = 1'b0;
      e_wreg_d  = 1'b0;
      e_rn_d    = '0;
    end else if (!stall) begin
      a_d       = d_shift ? {27'h0, imm[10:6]} : rs_val;
      b_d       = d_aluimm ? ext : rt_val;
      aluc_d    = d_aluc;
      e_valid_d = 1'b1;
      e_wreg_d  = d_wreg && (d_rn != 5'd0);
      e_rn_d    = d_rn;
    end
  end

  // Register-file write port; reset clears the array and drops any write-back
  always_ff @(posedge clk) begin
    if (!clrn) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_we && (wb_rn != 5'd0)) begin
      rf_q[wb_rn] <= wb_d;
    end
  end

  // Execute pipeline register
  always_ff @(posedge clk) begin
    a_q       <= a_d;
    b_q       <= b_d;
    aluc_q    <= aluc_d;
    e_valid_q <= e_valid_d;
    e_wreg_q  <= e_wreg_d;
    e_rn_q    <= e_rn_d;
  end

  assign a       = a_q;
  assign b       = b_q;
  assign aluc    = aluc_q;
  assign e_valid = e_valid_q;
  assign e_wreg  = e_wreg_q;
  assign e_rn    = e_rn_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a reference model computes the
// expected execute-register contents each cycle, pushes them to a scoreboard
// queue, and the entry is popped and compared after the clock edge.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        clrn, in_valid, d_aluimm, d_sext, d_shift, d_wreg;
  logic        stall, flush, wb_we;
  logic [4:0]  rs, rt, d_rn, wb_rn;
  logic [15:0] imm;
  logic [3:0]  d_aluc;
  logic [31:0] wb_d;
  logic [31:0] a, b;
  logic [3:0]  aluc;
  logic        e_valid, e_wreg;
  logic [4:0]  e_rn;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic        v;
    logic        w;
    logic [4:0]  rn;
  } exs_t;

  exs_t        mx;
  exs_t        exp_q [$];
  logic [31:0] mrf [32];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .rs(rs), .rt(rt), .imm(imm),
    .d_aluc(d_aluc), .d_aluimm(d_aluimm), .d_sext(d_sext), .d_shift(d_shift),
    .d_wreg(d_wreg), .d_rn(d_rn), .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_rn(wb_rn), .wb_d(wb_d),
    .a(a), .b(b), .aluc(aluc), .e_valid(e_valid), .e_wreg(e_wreg), .e_rn(e_rn)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  function automatic logic [31:0] rd(input logic [4:0] rn);
    if (rn == 5'd0) return 32'h0;
    if (wb_we && wb_rn == rn) return wb_d;
    return mrf[rn];
  endfunction

  // One clock: model the edge, push the expectation, clock the DUT, pop and compare
  task automatic step(input string tag);
    exs_t        nx, e;
    logic [31:0] ext, ra, rb;
    ext = d_sext ? {{16{imm[15]}}, imm} : {16'h0, imm};
    ra  = d_shift ? {27'h0, imm[10:6]} : rd(rs);
    rb  = d_aluimm ? ext : rd(rt);
    if (!clrn || flush)  nx = '0;
    else if (stall)      nx = mx;
    else if (!in_valid)  nx = '0;
    else                 nx = '{ra, rb, d_aluc, 1'b1, (d_wreg && d_rn != 5'd0), d_rn};
    exp_q.push_back(nx);
    if (!clrn) begin
      for (int i = 1; i < 32; i++) mrf[i] = 32'h0;
    end else if (wb_we && wb_rn != 5'd0) begin
      mrf[wb_rn] = wb_d;
    end
    mx = nx;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".a"},       a,               e.a);
      check({tag, ".b"},       b,               e.b);
      check({tag, ".aluc"},    {28'h0, aluc},   {28'h0, e.aluc});
      check({tag, ".e_valid"}, {31'h0, e_valid}, {31'h0, e.v});
      check({tag, ".e_wreg"},  {31'h0, e_wreg},  {31'h0, e.w});
      check({tag, ".e_rn"},    {27'h0, e_rn},    {27'h0, e.rn});
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; rs = 0; rt = 0; imm = 0; d_aluc = 0; d_aluimm = 0; d_sext = 0;
    d_shift = 0; d_wreg = 0; d_rn = 0; stall = 0; flush = 0;
    wb_we = 0; wb_rn = 0; wb_d = 0;
  endtask

  task automatic load(input logic [4:0] s, input logic [4:0] t, input logic [3:0] op,
                      input logic w, input logic [4:0] rn);
    in_valid = 1; rs = s; rt = t; d_aluc = op; d_wreg = w; d_rn = rn;
    d_aluimm = 0; d_sext = 0; d_shift = 0; imm = 16'h0;
  endtask

  task automatic wr(input logic [4:0] rn, input logic [31:0] d);
    wb_we = 1; wb_rn = rn; wb_d = d;
  endtask

  initial begin
    logic [31:0] held_a, held_b;
    for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
    mx = '0;
    idle_inputs();

    // Reset held two cycles, with noise on stall and write-back
    clrn = 0; stall = 1; wr(5'd4, 32'h1234_5678);
    step("rst0");
    step("rst1");
    check("rst.e_valid", {31'h0, e_valid}, 32'h0);
    idle_inputs();
    clrn = 1; rs = 5; rt = 31;
    step("rel");
    check("rel.a", a, 32'h0);
    check("rel.b", b, 32'h0);
    check("rel.e_valid", {31'h0, e_valid}, 32'h0);
    load(5, 31, 4'b0000, 1, 5'd2);
    step("rel_read");
    check("rel_read.a", a, 32'h0);

    // Write-through and register 0
    load(3, 0, 4'b0000, 1, 5'd3); wr(5'd3, 32'hDEAD_BEEF);
    step("wt");
    check("wt.a", a, 32'hDEAD_BEEF);
    wb_we = 0; load(0, 3, 4'b0001, 1, 5'd4);
    step("wt_stored");
    check("wt_stored.b", b, 32'hDEAD_BEEF);
    load(0, 0, 4'b0000, 1, 5'd1); wr(5'd0, 32'hFFFF_FFFF);
    step("r0_wt");
    check("r0_wt.a", a, 32'h0);
    wb_we = 0;
    step("r0_read");
    check("r0_read.a", a, 32'h0);

    // Immediate extension and shift amount
    load(3, 0, 4'b0000, 1, 5'd6); d_aluimm = 1; d_sext = 1; imm = 16'h8001;
    step("sext");
    check("sext.b", b, 32'hFFFF_8001);
    d_sext = 0;
    step("zext");
    check("zext.b", b, 32'h0000_8001);
    load(3, 3, 4'b0011, 1, 5'd7); d_shift = 1; imm = {5'b0, 5'd17, 6'b0};
    step("shamt");
    check("shamt.a", a, 32'd17);

    // Fill a few registers, then read them via ops
    for (int i = 1; i < 8; i++) begin
      idle_inputs(); wr(i[4:0], $urandom);
      step("fill");
    end
    idle_inputs();
    load(1, 2, 4'b0100, 1, 5'd8); step("op_sub");
    load(6, 7, 4'b1111, 1, 5'd9); step("op_sra");

    // Stall three cycles with changing inputs; write-back still lands
    load(4, 5, 4'b0100, 1, 5'd10);
    step("st_load");
    held_a = a; held_b = b;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      load(i[4:0] + 5'd1, 5'd6, 4'b0111, 0, 5'd20); stall = 1;
      in_valid = i[0]; wr(5'd9, 32'hA5A5_0000 + i);
      step("stall");
      check("stall.a_held", a, held_a);
      check("stall.b_held", b, held_b);
      check("stall.aluc", {28'h0, aluc}, 32'h4);
    end
    wb_we = 0; stall = 0; load(9, 0, 4'b0101, 1, 5'd11);
    step("stall_wb");
    check("stall_wb.a", a, 32'hA5A5_0002);
    stall = 1; flush = 1;
    step("st_fl");
    check("st_fl.e_valid", {31'h0, e_valid}, 32'h0);
    check("st_fl.a", a, 32'h0);

    // Tag rules
    idle_inputs(); load(1, 2, 4'b0010, 1, 5'd0);
    step("rn0");
    check("rn0.e_valid", {31'h0, e_valid}, 32'h1);
    check("rn0.e_wreg", {31'h0, e_wreg}, 32'h0);
    in_valid = 0; d_rn = 5'd12;
    step("inv");
    check("inv.e_rn", {27'h0, e_rn}, 32'h0);

    // Reset mid-stall with a write-back to r7 in the same cycle
    idle_inputs(); wr(5'd7, 32'h7777_7777); step("pre7");
    idle_inputs(); load(7, 7, 4'b0001, 1, 5'd7); step("ld7");
    stall = 1; wr(5'd7, 32'h1357_9BDF); clrn = 0;
    step("midrst");
    check("midrst.e_valid", {31'h0, e_valid}, 32'h0);
    idle_inputs(); clrn = 1; load(7, 7, 4'b0000, 1, 5'd1);
    step("after_rst");
    check("after_rst.a", a, 32'h0);
    check("after_rst.b", b, 32'h0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      clrn     = ($urandom_range(0, 40) != 0);
      in_valid = $urandom_range(0, 3) != 0;
      rs = $urandom; rt = $urandom; imm = $urandom; d_aluc = $urandom;
      d_aluimm = $urandom; d_sext = $urandom; d_shift = $urandom_range(0, 3) == 0;
      d_wreg = $urandom; d_rn = $urandom;
      stall = $urandom_range(0, 3) == 0; flush = $urandom_range(0, 7) == 0;
      wb_we = $urandom; wb_rn = $urandom; wb_d = $urandom;
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
